// File: rtl/mem_bus_pkg.sv
// Shared definitions for memory-bus initiators: DMA state encoding,
// word geometry and the request bundle an initiator drives onto the bus.
package mem_bus_pkg;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] FULL_MASK  = 4'hF;
    localparam int         BUS_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        FINISH  = 3'd5
    } dma_state_t;

    // Initiator-side request signals, registered by whoever owns them.
    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            wmask;
        logic                  rstrb;
    } bus_req_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter shared by the read and write wait phases of the DMA.
// lat_ok rises once the slave's minimum latency has elapsed; expired rises
// on the last permitted wait cycle. The count saturates there.
module bus_wait_timer #(
    parameter int MIN_LAT = 2,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic lat_ok,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Count wait cycles; cleared whenever the owner is not waiting.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign lat_ok  = (count >= CNT_W'(MIN_LAT - 1));
    assign expired = (count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_dma.sv
// Word-copy DMA initiator for the core-side memory bus.
// Copies cfg_len words from cfg_src to cfg_dst, one read then one write per
// word, honouring rbusy/wbusy and aborting with a sticky error on timeout.
// Optional build macro DMA_FILL_EN adds fill_mode/cfg_pattern: a fill writes
// the pattern to every destination word and issues no reads.
// Bus handshake: mem_rstrb and mem_wmask are single-cycle request strokes;
// mem_addr/mem_wdata stay stable until the slave drops its busy flag, and
// the slave response is never sampled before MIN_LAT cycles after the stroke.
module mem_bus_dma
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 10,
    parameter int MIN_LAT = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
`ifdef DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [31:0]       cfg_pattern,
`endif
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_rstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rbusy,
    input  logic              mem_wbusy,
    output dma_state_t        dbg_state
);

    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(WORD_BYTES);

    dma_state_t        state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;
    bus_req_t          req;
    logic              lat_ok;
    logic              expired;
    logic              timer_clear;

`ifdef DMA_FILL_EN
    logic              fill_q;
    logic [31:0]       pattern_q;
`else
    localparam logic        fill_q    = 1'b0;
    localparam logic [31:0] pattern_q = '0;
`endif

    assign timer_clear = !((state == RD_WAIT) || (state == WR_WAIT));

    bus_wait_timer #(
        .MIN_LAT (MIN_LAT),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .lat_ok  (lat_ok),
        .expired (expired)
    );

    // Transfer sequencer; bus strokes are registered on entry to the
    // request states so they are high for exactly that state's one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            req       <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef DMA_FILL_EN
            fill_q    <= 1'b0;
            pattern_q <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (cfg_len == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            src_ptr   <= cfg_src & ALIGN;
                            dst_ptr   <= cfg_dst & ALIGN;
                            remaining <= cfg_len;
`ifdef DMA_FILL_EN
                            fill_q    <= fill_mode;
                            pattern_q <= cfg_pattern;
                            if (fill_mode) begin
                                state     <= WR_REQ;
                                req.addr  <= BUS_ADDR_W'(cfg_dst & ALIGN);
                                req.wdata <= cfg_pattern;
                                req.wmask <= FULL_MASK;
                            end else begin
                                state     <= RD_REQ;
                                req.addr  <= BUS_ADDR_W'(cfg_src & ALIGN);
                                req.rstrb <= 1'b1;
                            end
`else
                            state     <= RD_REQ;
                            req.addr  <= BUS_ADDR_W'(cfg_src & ALIGN);
                            req.rstrb <= 1'b1;
`endif
                        end
                    end
                end
                RD_REQ: begin
                    req.rstrb <= 1'b0;
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_ok && !mem_rbusy) begin
                        state     <= WR_REQ;
                        req.addr  <= BUS_ADDR_W'(dst_ptr);
                        req.wdata <= mem_rdata;
                        req.wmask <= FULL_MASK;
                    end else if (expired) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                WR_REQ: begin
                    req.wmask <= '0;
                    state     <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (lat_ok && !mem_wbusy) begin
                        src_ptr   <= fill_q ? src_ptr : src_ptr + STEP;
                        dst_ptr   <= dst_ptr + STEP;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (fill_q) begin
                            state     <= WR_REQ;
                            req.addr  <= BUS_ADDR_W'(dst_ptr + STEP);
                            req.wdata <= pattern_q;
                            req.wmask <= FULL_MASK;
                        end else begin
                            state     <= RD_REQ;
                            req.addr  <= BUS_ADDR_W'(src_ptr + STEP);
                            req.rstrb <= 1'b1;
                        end
                    end else if (expired) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign mem_addr  = req.addr[ADDR_W-1:0];
    assign mem_wdata = req.wdata;
    assign mem_wmask = req.wmask;
    assign mem_rstrb = req.rstrb;
    assign dbg_state = state;

endmodule
